lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receiving end of the 16-bit Fibonacci LFSR pseudo-random stream used in the pipeline test harness.
- Takes one sampled word per valid cycle and self-synchronises by seeding its own LFSR from the received data.
- Once synchronised, predicts every following word, flags mismatches and keeps error and word statistics.
- Sits between the random-number source (or a memory/bus path carrying its output) and the debug/status registers.

Parameters:
- SYNC_WORDS, 4: consecutive correct predictions required to go from VERIFY to LOCKED (range 1..15).
- LOSS_WORDS, 8: consecutive mispredictions in LOCKED that drop back to HUNT (range 1..255).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- data_valid  input  1  data_in holds a stream word this cycle
- data_in  input  16  received LFSR word
- clear_stats  input  1  synchronous clear of err_count and word_count; lock state is kept
- locked  output  1  checker is in LOCKED
- error  output  1  one-cycle pulse: word checked in LOCKED did not match the prediction
- err_count  output  16  saturating count of error pulses
- word_count  output  32  saturating count of valid words checked in LOCKED
- state  output  2  00 HUNT, 01 VERIFY, 10 LOCKED (11 unused)

Behaviour:
- Next-state function: fb = w[0]^w[2]^w[3]^w[5]; next(w) = {fb, w[15:1]}. Example: next(0xACE1)=0x5670, next(0x5670)=0xAB38.
- Register expected[15:0] holds the prediction for the next valid word. Cycles with data_valid=0 change nothing.
- Reset (reset=1 at a clock edge, overriding all other inputs):
  - state=HUNT, expected=0, match counter=0, miss counter=0.
  - locked=0, error=0, err_count=0, word_count=0.
- HUNT, on a valid word:
  - data_in==0: stay in HUNT (all-zero is a lockup word and is never seeded).
  - otherwise: expected<=next(data_in), match counter<=0, go to VERIFY.
- VERIFY, on a valid word:
  - data_in==expected: match counter+1 and expected<=next(expected). When the count reaches SYNC_WORDS, go to LOCKED with miss counter=0.
  - mismatch: reseed from this word exactly as in HUNT, match counter=0, stay in VERIFY (HUNT if data_in==0).
  - No error pulses and no counting in VERIFY.
- LOCKED, on a valid word:
  - expected always advances to next(expected). It is never reseeded from data, so single bit errors do not corrupt the reference.
  - word_count increments, saturating at 0xFFFFFFFF.
  - match: miss counter<=0.
  - mismatch: error=1 next cycle, err_count increments (saturating at 0xFFFF), miss counter+1.
  - When the miss counter reaches LOSS_WORDS, go to HUNT and set locked=0. That final mismatch is still pulsed and counted.
- Timing: outputs are registered. error, locked and counters reflect a valid word one cycle after it is sampled.
  - locked rises in the cycle after the SYNC_WORDS-th match is sampled.
  - error is 0 in every cycle not caused by a LOCKED mismatch.
- clear_stats in the same cycle as an error event: the clear wins and err_count=0. The error pulse is still issued.
- Reset in the middle of VERIFY or LOCKED: state returns to HUNT next cycle, and statistics and the prediction are discarded.
- Latency from the first valid nonzero word to locked=1 is SYNC_WORDS+1 valid words plus one cycle.

Test Plan:
- Reset, then feed 0xACE1, 0x5670, 0xAB38 and two further correct successors with valid every cycle (SYNC_WORDS=4): locked=1 one cycle after the 5th word; err_count=0; word_count=0.
- Locked; insert gaps with data_valid=0 between correct words: no error; word_count counts valid words only; expected does not advance during gaps.
- Locked; flip bit 3 of one word, then continue with correct words: exactly one error pulse; err_count=1; locked stays 1; the following correct words raise no errors.
- Locked; feed 8 consecutive wrong words (LOSS_WORDS=8): 8 error pulses; err_count=8; locked=0 and state=HUNT after the 8th; relocks on a fresh correct stream.
- Feed 0x0000 repeatedly: stays in HUNT. In VERIFY after seed 0xACE1, feed 0x1234: reseeds and expects next(0x1234)=0x091A; locked stays 0.
- Assert reset while locked with err_count=5 -> all outputs 0 next cycle. Assert clear_stats together with an error event -> err_count=0 and error=1.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 16-bit Fibonacci LFSR test stream: self-seeds from
// incoming words, verifies a run of predictions, then flags and counts mismatches.
module lfsr_checker #(
  parameter int unsigned SYNC_WORDS = 4,
  parameter int unsigned LOSS_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_valid,
  input  logic [15:0] data_in,
  input  logic        clear_stats,
  output logic        locked,
  output logic        error,
  output logic [15:0] err_count,
  output logic [31:0] word_count,
  output logic [1:0]  state
);

  localparam logic [1:0] ST_HUNT   = 2'b00;
  localparam logic [1:0] ST_VERIFY = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  localparam logic [3:0] SYNC_LIM = 4'(SYNC_WORDS);
  localparam logic [7:0] LOSS_LIM = 8'(LOSS_WORDS);

  function automatic logic [15:0] lfsr_next(input logic [15:0] w);
    lfsr_next = {w[0] ^ w[2] ^ w[3] ^ w[5], w[15:1]};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] expected_q, expected_d;
  logic [3:0]  match_q, match_d;
  logic [7:0]  miss_q, miss_d;
  logic        locked_q, locked_d;
  logic        error_q, error_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] word_count_q, word_count_d;
  logic        mismatch_s;
  logic        err_event_s;
  logic        word_event_s;

  // Next-state logic for the hunt/verify/lock sequence and the statistics.
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    match_d      = match_q;
    miss_d       = miss_q;
    err_event_s  = 1'b0;
    word_event_s = 1'b0;
    mismatch_s   = (data_in != expected_q);

    case (state_q)
      ST_HUNT: begin
        // The all-zero word is the LFSR lockup state and is never used as a seed.
        if (data_valid && (data_in != 16'h0000)) begin
          expected_d = lfsr_next(data_in);
          match_d    = 4'd0;
          state_d    = ST_VERIFY;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_VERIFY: begin
        if (data_valid && !mismatch_s) begin
          match_d    = match_q + 4'd1;
          expected_d = lfsr_next(expected_q);
          if (match_d == SYNC_LIM) begin
            state_d = ST_LOCKED;
            miss_d  = 8'd0;
          end else begin
            state_d = ST_VERIFY;
          end
        end else if (data_valid && (data_in != 16'h0000)) begin
          expected_d = lfsr_next(data_in);
          match_d    = 4'd0;
          state_d    = ST_VERIFY;
        end else if (data_valid) begin
          match_d = 4'd0;
          state_d = ST_HUNT;
        end else begin
          state_d = ST_VERIFY;
        end
      end
      ST_LOCKED: begin
        // Once locked the reference free-runs so corrupted words cannot derail it.
        if (data_valid) begin
          expected_d   = lfsr_next(expected_q);
          word_event_s = 1'b1;
          if (mismatch_s) begin
            err_event_s = 1'b1;
            miss_d      = miss_q + 8'd1;
            if (miss_d == LOSS_LIM) begin
              state_d = ST_HUNT;
            end else begin
              state_d = ST_LOCKED;
            end
          end else begin
            miss_d  = 8'd0;
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_HUNT;
        match_d = 4'd0;
        miss_d  = 8'd0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
    error_d  = err_event_s;

    // A simultaneous clear takes priority over an increment.
    if (clear_stats) begin
      err_count_d = 16'h0000;
    end else if (err_event_s && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'h0001;
    end else begin
      err_count_d = err_count_q;
    end

    if (clear_stats) begin
      word_count_d = 32'h0000_0000;
    end else if (word_event_s && (word_count_q != 32'hFFFF_FFFF)) begin
      word_count_d = word_count_q + 32'h0000_0001;
    end else begin
      word_count_d = word_count_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      expected_q   <= 16'h0000;
      match_q      <= 4'd0;
      miss_q       <= 8'd0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
      err_count_q  <= 16'h0000;
      word_count_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      match_q      <= match_d;
      miss_q       <= miss_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  assign locked     = locked_q;
  assign error      = error_q;
  assign err_count  = err_count_q;
  assign word_count = word_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: sync, gaps, single bit error, loss of lock,
// zero-word hunting, reseed in VERIFY, reset while locked and clear/error collision.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_valid;
  logic [15:0] data_in;
  logic        clear_stats;
  logic        locked;
  logic        error;
  logic [15:0] err_count;
  logic [31:0] word_count;
  logic [1:0]  state;

  int passed = 0;
  int total  = 0;
  logic [15:0] w;

  lfsr_checker #(.SYNC_WORDS(4), .LOSS_WORDS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_valid (data_valid),
    .data_in    (data_in),
    .clear_stats(clear_stats),
    .locked     (locked),
    .error      (error),
    .err_count  (err_count),
    .word_count (word_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic clr);
    data_valid  = v;
    data_in     = d;
    clear_stats = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; data_valid = 1'b0; data_in = 16'h0000; clear_stats = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_errcnt", {16'd0, err_count}, 32'd0);
    chk("rst_wordcnt", word_count, 32'd0);
    reset = 1'b0;

    // Synchronise on the documented stream.
    step(1'b1, 16'hACE1, 1'b0);
    chk("seed_state", {30'd0, state}, 32'd1);
    step(1'b1, 16'h5670, 1'b0);
    step(1'b1, 16'hAB38, 1'b0);
    w = 16'hAB38;
    w = nxt(w); step(1'b1, w, 1'b0);
    chk("sync4_locked", {31'd0, locked}, 32'd0);
    w = nxt(w); step(1'b1, w, 1'b0);
    chk("sync5_locked", {31'd0, locked}, 32'd1);
    chk("sync5_state", {30'd0, state}, 32'd2);
    chk("sync5_errcnt", {16'd0, err_count}, 32'd0);
    chk("sync5_wordcnt", word_count, 32'd0);

    // Gaps with garbage data must not check or advance.
    w = nxt(w); step(1'b1, w, 1'b0);
    chk("gap_err0", {31'd0, error}, 32'd0);
    step(1'b0, 16'hFFFF, 1'b0);
    chk("gap_err1", {31'd0, error}, 32'd0);
    step(1'b0, 16'h0000, 1'b0);
    chk("gap_wordcnt1", word_count, 32'd1);
    w = nxt(w); step(1'b1, w, 1'b0);
    chk("gap_err2", {31'd0, error}, 32'd0);
    chk("gap_wordcnt2", word_count, 32'd2);

    // Single bit error.
    w = nxt(w); step(1'b1, w ^ 16'h0008, 1'b0);
    chk("flip_err", {31'd0, error}, 32'd1);
    chk("flip_errcnt", {16'd0, err_count}, 32'd1);
    chk("flip_locked", {31'd0, locked}, 32'd1);
    w = nxt(w); step(1'b1, w, 1'b0);
    chk("flip_after1", {31'd0, error}, 32'd0);
    chk("flip_errcnt2", {16'd0, err_count}, 32'd1);
    w = nxt(w); step(1'b1, w, 1'b0);
    chk("flip_after2", {31'd0, error}, 32'd0);
    chk("flip_wordcnt", word_count, 32'd5);

    // Clear keeps lock.
    step(1'b0, 16'h0000, 1'b1);
    chk("clr_errcnt", {16'd0, err_count}, 32'd0);
    chk("clr_wordcnt", word_count, 32'd0);
    chk("clr_locked", {31'd0, locked}, 32'd1);

    // Loss of lock after eight consecutive misses.
    for (int i = 0; i < 8; i++) begin
      w = nxt(w); step(1'b1, ~w, 1'b0);
      chk("loss_err", {31'd0, error}, 32'd1);
      if (i == 6) chk("loss7_locked", {31'd0, locked}, 32'd1);
    end
    chk("loss_locked", {31'd0, locked}, 32'd0);
    chk("loss_state", {30'd0, state}, 32'd0);
    chk("loss_errcnt", {16'd0, err_count}, 32'd8);
    chk("loss_wordcnt", word_count, 32'd8);
    step(1'b0, 16'h0000, 1'b0);
    chk("loss_idle_err", {31'd0, error}, 32'd0);

    // Relock on a fresh stream.
    w = 16'hACE1; step(1'b1, w, 1'b0);
    for (int i = 0; i < 4; i++) begin
      w = nxt(w); step(1'b1, w, 1'b0);
    end
    chk("relock_locked", {31'd0, locked}, 32'd1);
    chk("relock_state", {30'd0, state}, 32'd2);

    // Five errors while locked, then reset.
    step(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      w = nxt(w); step(1'b1, ~w, 1'b0);
    end
    chk("five_errcnt", {16'd0, err_count}, 32'd5);
    chk("five_locked", {31'd0, locked}, 32'd1);
    reset = 1'b1;
    step(1'b1, 16'h1111, 1'b0);
    reset = 1'b0;
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_locked", {31'd0, locked}, 32'd0);
    chk("mid_rst_error", {31'd0, error}, 32'd0);
    chk("mid_rst_errcnt", {16'd0, err_count}, 32'd0);
    chk("mid_rst_wordcnt", word_count, 32'd0);

    // Zero words never seed.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0000, 1'b0);
    chk("zero_state", {30'd0, state}, 32'd0);

    // Reseed inside VERIFY.
    step(1'b1, 16'hACE1, 1'b0);
    chk("vfy_state", {30'd0, state}, 32'd1);
    step(1'b1, 16'h1234, 1'b0);
    chk("reseed_state", {30'd0, state}, 32'd1);
    chk("reseed_locked", {31'd0, locked}, 32'd0);
    w = 16'h091A; step(1'b1, w, 1'b0);
    chk("reseed_m1_state", {30'd0, state}, 32'd1);
    w = nxt(w); step(1'b1, w, 1'b0);
    w = nxt(w); step(1'b1, w, 1'b0);
    chk("reseed_m3_locked", {31'd0, locked}, 32'd0);
    chk("reseed_error", {31'd0, error}, 32'd0);
    w = nxt(w); step(1'b1, w, 1'b0);
    chk("reseed_m4_locked", {31'd0, locked}, 32'd1);

    // Clear coinciding with an error event.
    w = nxt(w); step(1'b1, ~w, 1'b1);
    chk("clrerr_error", {31'd0, error}, 32'd1);
    chk("clrerr_errcnt", {16'd0, err_count}, 32'd0);
    w = nxt(w); step(1'b1, w, 1'b0);
    chk("clrerr_next_error", {31'd0, error}, 32'd0);
    chk("clrerr_next_errcnt", {16'd0, err_count}, 32'd0);
    chk("clrerr_wordcnt", word_count, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
